// File: rtl/cwc_capture_reader_if.sv
// cwc_capture_reader_if: capture-write snoop, RAM read port and
// sample stream bundle between capture logic, sample RAM and uploader.
interface cwc_capture_reader_if #(
    parameter int DATA_WIDTH = 48,
    parameter int ADDR_WIDTH = 16
);
    logic                  wt_ce;
    logic                  wt_en;
    logic [ADDR_WIDTH-1:0] wt_addr;
    logic                  clear;
    logic                  start;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  dout_last;
    logic                  busy;
    logic                  done;
    logic                  overrun;
    logic [ADDR_WIDTH-1:0] fill;

    modport master (
        output wt_ce, wt_en, wt_addr, clear, start,
        output rd_data, dout_ready,
        input  rd_en, rd_addr, dout, dout_valid, dout_last,
        input  busy, done, overrun, fill
    );

    modport slave (
        input  wt_ce, wt_en, wt_addr, clear, start,
        input  rd_data, dout_ready,
        output rd_en, rd_addr, dout, dout_valid, dout_last,
        output busy, done, overrun, fill
    );
endinterface

// File: rtl/cwc_capture_reader.sv
// cwc_capture_reader: tracks capture fill / write pointer and streams
// the circular sample RAM back oldest-first over valid/ready.
module cwc_capture_reader #(
    parameter int DATA_WIDTH = 48,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 2730
) (
    input  logic                 i_trig_clk,
    input  logic                 i_trig_rst,
    cwc_capture_reader_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_DEPTH = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_ZERO  = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_remain;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;
    logic                  r_dout_last;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overrun;
    logic [ADDR_WIDTH-1:0] r_fill;
    logic [ADDR_WIDTH-1:0] r_last_addr;

    logic                  w_wr;
    logic                  w_wrapped;
    logic [ADDR_WIDTH-1:0] w_start_ptr;
    logic [ADDR_WIDTH-1:0] w_start_next;
    logic [ADDR_WIDTH-1:0] w_next_ptr;

    assign w_wr      = bus.wt_ce & bus.wt_en;
    assign w_wrapped = (r_fill == LP_DEPTH);

    // Oldest sample sits just after the last write once the ring has wrapped.
    assign w_start_ptr  = !w_wrapped ? LP_ZERO :
                          (r_last_addr == LP_LAST) ? LP_ZERO :
                          r_last_addr + LP_ONE;
    assign w_start_next = (w_start_ptr == LP_LAST) ? LP_ZERO :
                          w_start_ptr + LP_ONE;
    assign w_next_ptr   = (r_rd_ptr == LP_LAST) ? LP_ZERO :
                          r_rd_ptr + LP_ONE;

    // Fill level, last write address and sticky overrun from the write snoop.
    always_ff @(posedge i_trig_clk) begin
        if (i_trig_rst) begin
            r_fill      <= '0;
            r_last_addr <= LP_LAST;
            r_overrun   <= 1'b0;
        end else if (bus.clear && !r_busy) begin
            r_fill      <= '0;
            r_last_addr <= LP_LAST;
            r_overrun   <= 1'b0;
        end else if (w_wr) begin
            r_last_addr <= bus.wt_addr;
            if (r_fill != LP_DEPTH) begin
                r_fill <= r_fill + LP_ONE;
            end
            if (r_busy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Readback FSM; the read strobe is registered on entry to ISSUE so the
    // pointer advance and count decrement happen on that same edge.
    always_ff @(posedge i_trig_clk) begin
        if (i_trig_rst) begin
            r_state      <= S_IDLE;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_ptr     <= '0;
            r_remain     <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.wt_ce) begin
                        r_busy <= 1'b1;
                        if (r_fill == LP_ZERO) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= w_start_ptr;
                            r_rd_ptr  <= w_start_next;
                            r_remain  <= r_fill - LP_ONE;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_dout       <= bus.rd_data;
                    r_dout_valid <= 1'b1;
                    r_dout_last  <= (r_remain == LP_ZERO);
                    r_state      <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_dout_last  <= 1'b0;
                        if (r_dout_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= r_rd_ptr;
                            r_rd_ptr  <= w_next_ptr;
                            r_remain  <= r_remain - LP_ONE;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_en      = r_rd_en;
    assign bus.rd_addr    = r_rd_addr;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dout_last  = r_dout_last;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.overrun    = r_overrun;
    assign bus.fill       = r_fill;

endmodule

// File: tb/tb_cwc_capture_reader.sv
// tb_cwc_capture_reader: directed bench with a RAM, a history-queue
// model of the capture ring and a per-cycle compare process.
module tb_cwc_capture_reader;

    localparam int DW    = 48;
    localparam int AW    = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cwc_capture_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cwc_capture_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .i_trig_clk(clk),
        .i_trig_rst(rst),
        .bus       (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Sample RAM
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] wt_data;

    always @(posedge clk) begin
        if (bus.wt_ce && bus.wt_en) mem[bus.wt_addr[2:0]] <= wt_data;
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[2:0]];
    end

    // Model: queue of written addresses (newest last), capped at DEPTH
    int            hist[$];
    int            exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int            m_fill  = 0;
    bit            m_over  = 0;
    int            m_phase = 0;
    bit            hs_last = 0;

    always @(posedge clk) begin : model
        int ph;
        ph = m_phase;
        if (rst) begin
            hist.delete();
            exp_addr.delete();
            exp_data.delete();
            m_over  = 0;
            m_phase = 0;
            hs_last = 0;
        end else begin
            if (ph == 0 && bus.start && !bus.wt_ce) begin
                exp_addr.delete();
                exp_data.delete();
                foreach (hist[i]) begin
                    exp_addr.push_back(hist[i]);
                    exp_data.push_back(mem[hist[i]]);
                end
                m_phase = (hist.size() == 0) ? 2 : 1;
            end else if (ph == 2) begin
                m_phase = 0;
            end else if (ph == 1 && hs_last) begin
                m_phase = 2;
            end
            hs_last = 0;
            if (bus.clear && ph == 0) begin
                hist.delete();
                m_over = 0;
            end else if (bus.wt_ce && bus.wt_en) begin
                hist.push_back(int'(bus.wt_addr));
                if (hist.size() > DEPTH) void'(hist.pop_front());
                if (ph != 0) m_over = 1;
            end
        end
        m_fill = hist.size();
    end

    // Compare process
    bit            chk_en = 0;
    int            seen[$];
    int            done_cnt = 0;
    int            hs_cnt = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_dout;
    logic          prev_last;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fill", 64'(bus.fill), 64'(m_fill));
            chk("overrun", 64'(bus.overrun), 64'(m_over));
            chk("busy", 64'(bus.busy), 64'(m_phase != 0));
            chk("done", 64'(bus.done), 64'(m_phase == 2));
            if (bus.done) done_cnt++;
            if (m_phase != 1) begin
                chk("rd_en_quiet", 64'(bus.rd_en), 64'(0));
                chk("valid_quiet", 64'(bus.dout_valid), 64'(0));
            end
            if (bus.rd_en) begin
                seen.push_back(int'(bus.rd_addr));
                chk("rd_addr_range", 64'(bus.rd_addr < AW'(DEPTH)), 64'(1));
                chk("rd_pending", 64'(exp_addr.size() != 0), 64'(1));
                if (exp_addr.size() != 0)
                    chk("rd_addr", 64'(bus.rd_addr), 64'(exp_addr.pop_front()));
            end
            if (bus.dout_valid) begin
                if (prev_stall) begin
                    chk("hold_dout", 64'(bus.dout), 64'(prev_dout));
                    chk("hold_last", 64'(bus.dout_last), 64'(prev_last));
                end
                if (bus.dout_ready) begin
                    hs_cnt++;
                    chk("dout_pending", 64'(exp_data.size() != 0), 64'(1));
                    if (exp_data.size() != 0) begin
                        chk("dout", 64'(bus.dout), 64'(exp_data.pop_front()));
                        chk("dout_last", 64'(bus.dout_last),
                            64'(exp_data.size() == 0));
                        hs_last = (exp_data.size() == 0);
                    end
                end
            end
            prev_stall = bus.dout_valid && !bus.dout_ready;
            prev_dout  = bus.dout;
            prev_last  = bus.dout_last;
        end
    end

    // Consumer ready: fixed level or random stalls of at most 10 cycles
    bit   rand_mode = 0;
    logic rdy_fixed = 1'b1;
    int   low_run   = 0;

    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            if (low_run >= 10 || $urandom_range(0, 2) == 0) begin
                bus.dout_ready = 1'b1;
                low_run = 0;
            end else begin
                bus.dout_ready = 1'b0;
                low_run++;
            end
        end else begin
            bus.dout_ready = rdy_fixed;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int a, logic [DW-1:0] d);
        bus.wt_en   = 1'b1;
        bus.wt_addr = AW'(a);
        wt_data     = d;
        tick();
        bus.wt_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int k;
        k = 0;
        while (bus.busy && k < budget) begin
            tick();
            k++;
        end
        chk("idle_timeout", 64'(bus.busy), 64'(0));
    endtask

    task automatic chk_reset();
        chk("rst_rd_en", 64'(bus.rd_en), 64'(0));
        chk("rst_rd_addr", 64'(bus.rd_addr), 64'(0));
        chk("rst_dout", 64'(bus.dout), 64'(0));
        chk("rst_valid", 64'(bus.dout_valid), 64'(0));
        chk("rst_last", 64'(bus.dout_last), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_overrun", 64'(bus.overrun), 64'(0));
        chk("rst_fill", 64'(bus.fill), 64'(0));
    endtask

    int e1[5] = '{0, 1, 2, 3, 4};
    int e2[8] = '{3, 4, 5, 6, 7, 0, 1, 2};
    int e5[4] = '{0, 1, 2, 3};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.wt_ce   = 1'b0;
        bus.wt_en   = 1'b0;
        bus.wt_addr = '0;
        bus.clear   = 1'b0;
        bus.start   = 1'b0;
        wt_data     = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        rst = 1'b1;
        repeat (3) tick();
        chk_reset();
        rst = 1'b0;
        chk_en = 1;

        // 5 linear writes, in-order readback
        bus.wt_ce = 1'b1;
        for (int i = 0; i < 5; i++) wr(i, 48'h1000 + 48'(i));
        bus.wt_ce = 1'b0;
        tick();
        chk("t1_fill", 64'(bus.fill), 64'(5));
        seen.delete();
        done_cnt = 0;
        pulse_start();
        chk("t1_rd_en_n1", 64'(bus.rd_en), 64'(1));
        chk("t1_rd_addr_n1", 64'(bus.rd_addr), 64'(0));
        tick();
        tick();
        chk("t1_valid_n3", 64'(bus.dout_valid), 64'(1));
        chk("t1_dout_n3", 64'(bus.dout), 64'h1000);
        wait_idle(100);
        chk("t1_len", 64'(seen.size()), 64'(5));
        for (int i = 0; i < 5; i++)
            if (i < seen.size()) chk("t1_order", 64'(seen[i]), 64'(e1[i]));
        chk("t1_done_cnt", 64'(done_cnt), 64'(1));
        chk("t1_fill_after", 64'(bus.fill), 64'(5));

        // 11 writes wrap the ring, oldest-first from address 3
        pulse_clear();
        bus.wt_ce = 1'b1;
        for (int i = 0; i < 11; i++) wr(i % 8, 48'h2000 + 48'(i));
        bus.wt_ce = 1'b0;
        tick();
        chk("t2_fill", 64'(bus.fill), 64'(8));
        seen.delete();
        hs_cnt = 0;
        pulse_start();
        chk("t2_first_addr", 64'(bus.rd_addr), 64'(3));
        tick();
        tick();
        chk("t2_first_dout", 64'(bus.dout), 64'h2003);
        wait_idle(200);
        chk("t2_len", 64'(seen.size()), 64'(8));
        for (int i = 0; i < 8; i++)
            if (i < seen.size()) chk("t2_order", 64'(seen[i]), 64'(e2[i]));
        chk("t2_hs_cnt", 64'(hs_cnt), 64'(8));

        // Empty readback, then start blocked by capture active
        pulse_clear();
        chk("t3_fill", 64'(bus.fill), 64'(0));
        seen.delete();
        done_cnt = 0;
        pulse_start();
        chk("t3_done", 64'(bus.done), 64'(1));
        chk("t3_busy", 64'(bus.busy), 64'(1));
        tick();
        chk("t3_done_end", 64'(bus.done), 64'(0));
        chk("t3_busy_end", 64'(bus.busy), 64'(0));
        chk("t3_no_reads", 64'(seen.size()), 64'(0));
        chk("t3_done_cnt", 64'(done_cnt), 64'(1));
        bus.wt_ce = 1'b1;
        pulse_start();
        chk("t3_blocked", 64'(bus.busy), 64'(0));
        tick();
        chk("t3_blocked2", 64'(bus.busy), 64'(0));
        bus.wt_ce = 1'b0;

        // Random backpressure
        pulse_clear();
        bus.wt_ce = 1'b1;
        for (int i = 0; i < 6; i++) wr(i, 48'hABC0_0000 + 48'(i * 3));
        bus.wt_ce = 1'b0;
        tick();
        rand_mode = 1;
        hs_cnt = 0;
        pulse_start();
        wait_idle(1000);
        rand_mode = 0;
        tick();
        chk("t4_hs_cnt", 64'(hs_cnt), 64'(6));

        // Write during readback sets sticky overrun
        pulse_clear();
        bus.wt_ce = 1'b1;
        for (int i = 0; i < 4; i++) wr(i, 48'h5000 + 48'(i));
        bus.wt_ce = 1'b0;
        tick();
        seen.delete();
        hs_cnt = 0;
        pulse_start();
        begin
            int k;
            k = 0;
            while (hs_cnt == 0 && k < 50) begin
                tick();
                k++;
            end
        end
        chk("t5_first_hs", 64'(hs_cnt > 0), 64'(1));
        bus.wt_ce = 1'b1;
        wr(0, 48'h5FFF);
        bus.wt_ce = 1'b0;
        tick();
        chk("t5_overrun", 64'(bus.overrun), 64'(1));
        wait_idle(100);
        chk("t5_len", 64'(seen.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < seen.size()) chk("t5_order", 64'(seen[i]), 64'(e5[i]));
        chk("t5_overrun_sticky", 64'(bus.overrun), 64'(1));
        chk("t5_fill", 64'(bus.fill), 64'(5));
        pulse_clear();
        chk("t5_overrun_clr", 64'(bus.overrun), 64'(0));

        // Reset while holding an unaccepted sample
        bus.wt_ce = 1'b1;
        for (int i = 0; i < 3; i++) wr(i, 48'h7000 + 48'(i));
        bus.wt_ce = 1'b0;
        rdy_fixed = 1'b0;
        tick();
        tick();
        done_cnt = 0;
        pulse_start();
        tick();
        tick();
        chk("t6_hold_valid", 64'(bus.dout_valid), 64'(1));
        tick();
        chk("t6_hold_valid2", 64'(bus.dout_valid), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset();
        rdy_fixed = 1'b1;
        repeat (5) tick();
        chk("t6_no_done", 64'(done_cnt), 64'(0));
        chk("t6_idle", 64'(bus.busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cwc_capture_reader.md
# cwc_capture_reader

Read-side companion to the ChipWatcher capture path. It snoops the sample-memory write strobes (`wt_ce`, `wt_en`, `wt_addr`) produced by `cwc_top`, tracks fill level and the circular-buffer write pointer, and, on request, reads the sample RAM back in chronological order (oldest first) as a valid/ready stream toward the JTAG upload logic. It sits between the capture RAM read port and the readback shifter, in the `trig_clk` domain.

## Interface

- `DATA_WIDTH`, 48, sample width (= BUS_NODE_NUM + NON_BUS_NODE_NUM)
- `ADDR_WIDTH`, 16, width of `wt_addr` / `rd_addr`
- `DEPTH`, 2730, number of sample slots (= STOP_LEN); addresses 0..DEPTH-1

- `trig_clk`  in  1  sole clock; all logic is rising-edge
- `trig_rst`  in  1  reset, synchronous, active-high
- `wt_ce`  in  1  capture active (from cwc_top)
- `wt_en`  in  1  sample write strobe (from cwc_top)
- `wt_addr`  in  ADDR_WIDTH  address of current write
- `clear`  in  1  single-cycle pulse: forget captured contents
- `start`  in  1  single-cycle pulse: begin readback
- `rd_en`  out  1  RAM read enable
- `rd_addr`  out  ADDR_WIDTH  RAM read address
- `rd_data`  in  DATA_WIDTH  RAM data, valid exactly 1 cycle after `rd_en`
- `dout`  out  DATA_WIDTH  sample out
- `dout_valid`  out  1  `dout` valid
- `dout_ready`  in  1  consumer accepts
- `dout_last`  out  1  marks final sample of readback
- `busy`  out  1  readback in progress
- `done`  out  1  one-cycle pulse at readback end
- `overrun`  out  1  sticky: write seen while busy
- `fill`  out  ADDR_WIDTH  number of valid samples (saturates at DEPTH)

## Operation

- Write tracking (any state except during `trig_rst`): a write is `wt_ce & wt_en`. On a write: `last_addr <= wt_addr`; `fill <= min(fill+1, DEPTH)`. `wrapped` = (`fill == DEPTH`).
- `clear` sets `fill`=0, `last_addr`=DEPTH-1, `overrun`=0. `clear` and a write in the same cycle: `clear` wins, `fill`=0. `clear` while busy: ignored.
- FSM states: IDLE, ISSUE, WAIT, HOLD, DONE.
  - IDLE: `start` accepted only if `wt_ce`=0. Loads `rd_ptr` = wrapped ? (last_addr==DEPTH-1 ? 0 : last_addr+1) : 0, `remain` = `fill`. If `fill`=0 -> DONE, else -> ISSUE. `start` with `wt_ce`=1 ignored, stays IDLE.
  - ISSUE: `rd_en`=1, `rd_addr`=`rd_ptr`; advance `rd_ptr` (DEPTH-1 wraps to 0); decrement `remain` -> WAIT.
  - WAIT: capture `rd_data` into `dout`, set `dout_valid`; `dout_last` = (`remain`==0) -> HOLD.
  - HOLD: hold `dout`/`dout_valid`/`dout_last` stable until `dout_ready`. On handshake: if last -> DONE, else -> ISSUE.
  - DONE: `done`=1 for one cycle -> IDLE.
- `busy` = 1 in ISSUE, WAIT, HOLD, DONE.
- Write while busy: tracked normally (fill/last_addr update) and `overrun` set; readback continues with the pointer/count latched at start.
- `rd_addr` never exceeds DEPTH-1; `start` pulses while busy ignored.

## Timing

- Reset values: `rd_en`=0, `rd_addr`=0, `dout`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `done`=0, `overrun`=0, `fill`=0; internal `last_addr`=DEPTH-1; FSM IDLE.
- `start` at edge N -> `rd_en` in cycle N+1 -> `dout_valid` from N+3 (WAIT registers data at end of N+2).
- With `dout_ready` held high: one sample per 3 cycles (ISSUE, WAIT, HOLD).
- `done` asserts the cycle after the last handshake; `busy` drops the cycle after `done`.
- Empty readback: `start` at N -> `done` in N+1, no `dout_valid`.
- `trig_rst` mid-readback: all outputs to reset values next edge, no `done` pulse.

## Test plan

- DEPTH=8: 5 writes to addr 0..4 with `dout_ready`=1, then `start` -> reads addr 0,1,2,3,4, `dout_last` on 5th, `done` once, `fill`=5.
- DEPTH=8: 11 writes addr 0..7,0,1,2 -> `fill`=8, `start` -> read order 3,4,5,6,7,0,1,2; 8 samples, data matches RAM model.
- `clear` then `start` -> `done` one cycle later, no `rd_en`, no `dout_valid`; `start` with `wt_ce`=1 -> ignored, `busy` stays 0.
- Random `dout_ready` backpressure (stall up to 10 cycles) -> `dout` stable while `dout_valid` & !`dout_ready`, no sample lost or duplicated.
- Write strobe during readback -> `overrun`=1 sticky, sample sequence unchanged; `clear` in IDLE returns `overrun` to 0.
- `trig_rst` asserted in HOLD -> next cycle all outputs at reset values, `done` never pulses, `fill`=0.
